// File: rtl/sensor_conditioner.sv
// Irrigation controller input front-end.
// Synchronizes, debounces and qualifies the six raw field inputs.
module sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] raw_in,
    output logic       H,
    output logic       M,
    output logic       L,
    output logic       T,
    output logic       Us,
    output logic       Ua,
    output logic       sensors_valid,
    output logic       changed
);

    localparam int NCH = 6;

    // Terminal count of a channel filter; the compare happens before the
    // increment would reach DEBOUNCE_CYCLES, so the counter never wraps.
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEBOUNCE_CYCLES - 1);

    // One extra bit so DEBOUNCE_CYCLES+2 fits even at the top of the range.
    localparam logic [CNT_W:0] WARM_TOP = (CNT_W + 1)'(DEBOUNCE_CYCLES + 2);

    logic [NCH-1:0]   sync1_q;
    logic [NCH-1:0]   sync2_q;
    logic [NCH-1:0]   stable_q;
    logic [NCH-1:0]   stable_d;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [CNT_W:0]   wcnt_q;
    logic [CNT_W:0]   wcnt_d;
    logic             valid_q;
    logic             valid_d;
    logic             changed_q;
    logic             changed_d;

    // Two-flop synchronizer for the asynchronous field inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel debounce: a new level must persist for the full count.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_TOP) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Warm-up qualifier and change strobe; power-up captures are not reported.
    always_comb begin
        wcnt_d    = (wcnt_q == WARM_TOP) ? wcnt_q : wcnt_q + 1'b1;
        valid_d   = valid_q | (wcnt_d == WARM_TOP);
        changed_d = valid_q & (stable_d != stable_q);
    end

    // State registers for filters, warm-up and strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            stable_q  <= '0;
            wcnt_q    <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q  <= stable_d;
            wcnt_q    <= wcnt_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign H             = stable_q[5];
    assign M             = stable_q[4];
    assign L             = stable_q[3];
    assign T             = stable_q[2];
    assign Us            = stable_q[1];
    assign Ua            = stable_q[0];
    assign sensors_valid = valid_q;
    assign changed       = changed_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with DEBOUNCE_CYCLES=4.
// Outputs are sampled 1 time unit after each rising edge.
module tb_sensor_conditioner;

    localparam int D = 4;

    logic       clock;
    logic       reset;
    logic [5:0] raw_in;
    logic       H;
    logic       M;
    logic       L;
    logic       T;
    logic       Us;
    logic       Ua;
    logic       sensors_valid;
    logic       changed;

    int checks   = 0;
    int failures = 0;

    sensor_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .raw_in       (raw_in),
        .H            (H),
        .M            (M),
        .L            (L),
        .T            (T),
        .Us           (Us),
        .Ua           (Ua),
        .sensors_valid(sensors_valid),
        .changed      (changed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [5:0] outs();
        return {H, M, L, T, Us, Ua};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h required=%h", tag, obs, exp);
        end
    endtask

    // Reset for 3 edges, release, and follow warm-up for 6 edges.
    // Channels already at 'lvl' settle at edge 6, together with valid.
    task automatic warmup(input string tag, input logic [5:0] lvl);
        reset = 1'b1;
        repeat (3) step();
        chk({tag, "_rst_outs"}, {2'b00, outs()}, 8'h00);
        chk({tag, "_rst_valid"}, {7'd0, sensors_valid}, 8'h00);
        chk({tag, "_rst_chg"}, {7'd0, changed}, 8'h00);
        reset = 1'b0;
        for (int i = 1; i <= D + 2; i++) begin
            step();
            chk({tag, "_outs"}, {2'b00, outs()},
                {2'b00, (i >= D + 2) ? lvl : 6'b000000});
            chk({tag, "_valid"}, {7'd0, sensors_valid},
                {7'd0, (i >= D + 2)});
            chk({tag, "_chg"}, {7'd0, changed}, 8'h00);
        end
        repeat (3) begin
            step();
            chk({tag, "_hold"}, {2'b00, outs()}, {2'b00, lvl});
            chk({tag, "_hold_chg"}, {7'd0, changed}, 8'h00);
        end
    endtask

    // Drive a new raw value; the output follows after edge D+1.
    task automatic transition(input string tag, input logic [5:0] from,
                              input logic [5:0] to);
        raw_in = to;
        for (int i = 0; i <= D + 2; i++) begin
            step();
            chk({tag, "_outs"}, {2'b00, outs()},
                {2'b00, (i >= D + 1) ? to : from});
            chk({tag, "_chg"}, {7'd0, changed}, {7'd0, (i == D + 1)});
        end
    endtask

    initial begin
        reset  = 1'b1;
        raw_in = 6'b000000;

        // 1: quiet inputs, warm-up only.
        warmup("t1", 6'b000000);

        // 2: level switches high across reset release.
        raw_in = 6'b111000;
        warmup("t2", 6'b111000);

        // 3: T rises after valid.
        transition("t3", 6'b111000, 6'b111100);

        // 4: Us bounce 3 high, 1 low, 2 high, then low.
        raw_in = 6'b111110;
        repeat (3) begin
            step();
            chk("t4_a", {2'b00, outs()}, 8'h3C);
        end
        raw_in = 6'b111100;
        step();
        chk("t4_b", {2'b00, outs()}, 8'h3C);
        raw_in = 6'b111110;
        repeat (2) begin
            step();
            chk("t4_c", {2'b00, outs()}, 8'h3C);
        end
        raw_in = 6'b111100;
        repeat (8) begin
            step();
            chk("t4_outs", {2'b00, outs()}, 8'h3C);
            chk("t4_chg", {7'd0, changed}, 8'h00);
        end

        // 5: drop L, then Ua and L rise on the same cycle.
        transition("t5_lfall", 6'b111100, 6'b110100);
        transition("t5_both", 6'b110100, 6'b111101);

        // 6: drop M, then reset while M's counter is 2.
        transition("t6_mfall", 6'b111101, 6'b101101);
        raw_in = 6'b111101;
        for (int i = 0; i <= 3; i++) begin
            step();
            chk("t6_count", {2'b00, outs()}, 8'h2D);
        end
        reset = 1'b1;
        step();
        chk("t6_m_after_rst", {7'd0, M}, 8'h00);
        chk("t6_valid_drop", {7'd0, sensors_valid}, 8'h00);
        chk("t6_chg_rst", {7'd0, changed}, 8'h00);
        warmup("t6_rewarm", 6'b111101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
